// File: rtl/ysyx_24100012_branch_pkg.sv
// +----------------------------------------------------------------------------+
// | ysyx_24100012_branch_pkg : shared constants/types for the branch unit      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package ysyx_24100012_branch_pkg;

  localparam logic [1:0] PCTYPE_SEQ  = 2'b00;
  localparam logic [1:0] PCTYPE_BR   = 2'b01;
  localparam logic [1:0] PCTYPE_JAL  = 2'b10;
  localparam logic [1:0] PCTYPE_JALR = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_INIT = 2'b01;

  // Saturating 2-bit step: 00 <-> 11, never wraps.
  function automatic bht_ctr_t bht_next(input bht_ctr_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_24100012_bht.sv
// +----------------------------------------------------------------------------+
// | ysyx_24100012_bht : 2-bit saturating branch history table                  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ysyx_24100012_bht
  import ysyx_24100012_branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  bht_ctr_t ctr_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_INIT;
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= bht_next(ctr_q[wr_idx_i], wr_taken_i);
    end
  end

  // Read sees the stored value; a same-cycle update is not forwarded.
  assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

`default_nettype wire

// File: rtl/ysyx_24100012_branch_unit.sv
// +----------------------------------------------------------------------------+
// | ysyx_24100012_branch_unit : registered branch resolution with BHT + stats  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ysyx_24100012_branch_unit
  import ysyx_24100012_branch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  lookup_taken,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [ADDR_WIDTH-1:0] in_imm,
  input  logic [2:0]            in_func3,
  input  logic [1:0]            in_pctype,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic                  in_pred_taken,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_taken,
  output logic                  out_redirect,
  output logic [ADDR_WIDTH-1:0] out_next_pc,
  output logic [CNT_WIDTH-1:0]  stat_branches,
  output logic [CNT_WIDTH-1:0]  stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic                  cond;
  logic                  taken;
  logic                  redirect;
  logic                  is_br;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] jalr_sum;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] next_pc;

  logic                  out_valid_q, out_valid_d;
  logic                  out_taken_q;
  logic                  out_redirect_q;
  logic [ADDR_WIDTH-1:0] out_next_pc_q;
  logic [CNT_WIDTH-1:0]  stat_br_q, stat_br_d;
  logic [CNT_WIDTH-1:0]  stat_mp_q, stat_mp_d;
  logic                  unused_lookup_bits;

  always_comb begin
    cond = 1'b0;
    case (in_func3)
      F3_BEQ:  cond = (in_rs1 == in_rs2);
      F3_BNE:  cond = (in_rs1 != in_rs2);
      F3_BLT:  cond = ($signed(in_rs1) <  $signed(in_rs2));
      F3_BGE:  cond = ($signed(in_rs1) >= $signed(in_rs2));
      F3_BLTU: cond = (in_rs1 <  in_rs2);
      F3_BGEU: cond = (in_rs1 >= in_rs2);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken    = 1'b0;
    redirect = 1'b0;
    case (in_pctype)
      PCTYPE_SEQ:  begin taken = 1'b0; redirect = 1'b0; end
      PCTYPE_BR:   begin taken = cond; redirect = (cond != in_pred_taken); end
      default:     begin taken = 1'b1; redirect = 1'b1; end
    endcase
  end

  assign jalr_sum = ADDR_WIDTH'(in_rs1) + in_imm;
  assign target   = (in_pctype == PCTYPE_JALR) ? {jalr_sum[ADDR_WIDTH-1:1], 1'b0}
                                               : in_pc + in_imm;
  assign next_pc  = taken ? target : in_pc + ADDR_WIDTH'(4);

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign is_br    = (in_pctype == PCTYPE_BR);

  // Flush wins over both a new accept and a completing transfer.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (accept && is_br) begin
      if (stat_br_q != '1) stat_br_d = stat_br_q + CNT_WIDTH'(1);
      if (redirect && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_taken_q    <= 1'b0;
      out_redirect_q <= 1'b0;
      out_next_pc_q  <= '0;
      stat_br_q      <= '0;
      stat_mp_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      stat_br_q   <= stat_br_d;
      stat_mp_q   <= stat_mp_d;
      if (accept) begin
        out_taken_q    <= taken;
        out_redirect_q <= redirect;
        out_next_pc_q  <= next_pc;
      end
    end
  end

  ysyx_24100012_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (lookup_pc[IDX_W+1:2]),
    .rd_taken_o (lookup_taken),
    .wr_en_i    (accept && is_br),
    .wr_idx_i   (in_pc[IDX_W+1:2]),
    .wr_taken_i (taken)
  );

  assign unused_lookup_bits = ^{lookup_pc[ADDR_WIDTH-1:IDX_W+2], lookup_pc[1:0]};

  assign out_valid        = out_valid_q;
  assign out_taken        = out_taken_q;
  assign out_redirect     = out_redirect_q;
  assign out_next_pc      = out_next_pc_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100012_branch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_ysyx_24100012_branch_unit : directed bench with reference model        |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_24100012_branch_unit;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_imm;
  logic [2:0]  in_func3;
  logic [1:0]  in_pctype;
  logic [31:0] in_rs1, in_rs2;
  logic        in_pred_taken;
  logic        flush;
  logic        out_valid, out_ready;
  logic        out_taken, out_redirect;
  logic [31:0] out_next_pc;
  logic [CW-1:0] stat_branches, stat_mispredicts;

  ysyx_24100012_branch_unit #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BHT_ENTRIES(64), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_imm(in_imm),
    .in_func3(in_func3), .in_pctype(in_pctype), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_taken(out_taken), .out_redirect(out_redirect),
    .out_next_pc(out_next_pc), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid, m_taken, m_redirect;
  logic [31:0] m_next;
  int          m_br, m_mp;
  int          m_bht [64];
  bit          mt, mr, m_acc;
  logic [31:0] m_tgt;

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_taken = 0; m_redirect = 0; m_next = 0; m_br = 0; m_mp = 0;
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
    end else begin
      m_acc = in_valid && (!m_valid || out_ready) && !flush;
      case (in_func3)
        3'd0: mt = (in_rs1 == in_rs2);
        3'd1: mt = (in_rs1 != in_rs2);
        3'd4: mt = ($signed(in_rs1) <  $signed(in_rs2));
        3'd5: mt = ($signed(in_rs1) >= $signed(in_rs2));
        3'd6: mt = (in_rs1 <  in_rs2);
        3'd7: mt = (in_rs1 >= in_rs2);
        default: mt = 0;
      endcase
      if (in_pctype == 2'd0) mt = 0;
      else if (in_pctype != 2'd1) mt = 1;
      m_tgt = (in_pctype == 2'd3) ? ((in_rs1 + in_imm) & ~32'd1) : (in_pc + in_imm);
      mr = (in_pctype == 2'd1) ? (mt != in_pred_taken) : (in_pctype != 2'd0);
      if (flush) m_valid = 0;
      else if (m_acc) m_valid = 1;
      else if (out_ready) m_valid = 0;
      if (m_acc) begin
        m_taken = mt; m_redirect = mr;
        m_next = mt ? m_tgt : in_pc + 32'd4;
        if (in_pctype == 2'd1) begin
          if (mt) m_bht[idx(in_pc)] = (m_bht[idx(in_pc)] == 3) ? 3 : m_bht[idx(in_pc)] + 1;
          else    m_bht[idx(in_pc)] = (m_bht[idx(in_pc)] == 0) ? 0 : m_bht[idx(in_pc)] - 1;
          if (m_br < (1 << CW) - 1) m_br++;
          if (mr && m_mp < (1 << CW) - 1) m_mp++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("model_out_valid", out_valid, m_valid);
      chk("model_in_ready", in_ready, !m_valid || out_ready);
      chk("model_lookup", lookup_taken, m_bht[idx(lookup_pc)] >= 2);
      chk("model_stat_br", stat_branches, m_br);
      chk("model_stat_mp", stat_mispredicts, m_mp);
      if (m_valid) begin
        chk("model_taken", out_taken, m_taken);
        chk("model_redirect", out_redirect, m_redirect);
        chk("model_next_pc", out_next_pc, m_next);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                       input logic pred);
    in_valid = 1; in_pctype = t; in_func3 = f3; in_pc = pc; in_imm = imm;
    in_rs1 = a; in_rs2 = b; in_pred_taken = pred;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; flush = 0; out_ready = 1; in_valid = 0; in_pc = 0; in_imm = 0;
    in_func3 = 0; in_pctype = 0; in_rs1 = 0; in_rs2 = 0; in_pred_taken = 0;
    lookup_pc = 32'h8000_0000;
    step();
    checking = 1;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_next_pc", out_next_pc, 0);
    chk("rst_out_taken", out_taken, 0);
    chk("rst_out_redirect", out_redirect, 0);
    chk("rst_lookup", lookup_taken, 0);
    chk("rst_stat_br", stat_branches, 0);
    rst = 0;

    drive(2'b01, 3'b000, 32'h8000_0000, 32'h10, 32'd5, 32'd5, 1'b0);
    step(); in_valid = 0;
    chk("beq_taken", out_taken, 1);
    chk("beq_next_pc", out_next_pc, 32'h8000_0010);
    chk("beq_redirect", out_redirect, 1);
    chk("beq_stat_br", stat_branches, 1);
    chk("beq_stat_mp", stat_mispredicts, 1);
    chk("beq_bht_lookup", lookup_taken, 1);

    drive(2'b01, 3'b100, 32'h8000_0100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step();
    chk("blt_taken", out_taken, 1);
    chk("blt_next_pc", out_next_pc, 32'h8000_0120);
    chk("blt_redirect", out_redirect, 0);
    drive(2'b01, 3'b110, 32'h8000_0100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    chk("bltu_taken", out_taken, 0);
    chk("bltu_next_pc", out_next_pc, 32'h8000_0104);
    drive(2'b11, 3'b000, 32'h8000_0200, 32'h0, 32'h8000_0003, 32'd0, 1'b0);
    step(); in_valid = 0;
    chk("jalr_next_pc", out_next_pc, 32'h8000_0002);
    chk("jalr_redirect", out_redirect, 1);
    chk("jalr_stat_br", stat_branches, 3);
    chk("jalr_stat_mp", stat_mispredicts, 1);

    lookup_pc = 32'h8000_0040;
    #1 chk("sat_lookup_0", lookup_taken, 0);
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 3'b000, 32'h8000_0040, 32'h8, 32'd7, 32'd7, 1'b1);
      step();
      chk("sat_lookup_n", lookup_taken, 1);
    end
    drive(2'b01, 3'b001, 32'h8000_0040, 32'h8, 32'd7, 32'd7, 1'b1);
    step(); in_valid = 0;
    chk("nt_lookup", lookup_taken, 1);
    chk("nt_next_pc", out_next_pc, 32'h8000_0044);
    chk("nt_stat_br", stat_branches, 8);
    chk("nt_stat_mp", stat_mispredicts, 2);
    step();

    out_ready = 0;
    drive(2'b10, 3'b000, 32'h8000_0300, 32'h40, 32'd0, 32'd0, 1'b0);
    step();
    drive(2'b10, 3'b000, 32'h8000_0400, 32'h8, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_next_pc", out_next_pc, 32'h8000_0340);
    end
    out_ready = 1;
    step();
    chk("bp_release_next_pc", out_next_pc, 32'h8000_0408);
    drive(2'b10, 3'b000, 32'h8000_0500, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0);
    step(); in_valid = 0;
    chk("bp_next_next_pc", out_next_pc, 32'h8000_04FC);
    step();

    out_ready = 0;
    drive(2'b10, 3'b000, 32'h8000_0600, 32'h10, 32'd0, 32'd0, 1'b0);
    step();
    drive(2'b01, 3'b001, 32'h8000_0040, 32'h8, 32'd3, 32'd3, 1'b1);
    flush = 1; out_ready = 1;
    step(); flush = 0; in_valid = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_bht_lookup", lookup_taken, 1);
    chk("flush_stat_br", stat_branches, 8);
    chk("flush_stat_mp", stat_mispredicts, 2);
    step();

    drive(2'b10, 3'b000, 32'h8000_0700, 32'h10, 32'd0, 32'd0, 1'b0);
    step();
    drive(2'b01, 3'b000, 32'h8000_0040, 32'h8, 32'd3, 32'd3, 1'b0);
    rst = 1;
    step(); rst = 0; in_valid = 0;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_next_pc", out_next_pc, 0);
    chk("mrst_lookup", lookup_taken, 0);
    chk("mrst_stat_br", stat_branches, 0);
    chk("mrst_stat_mp", stat_mispredicts, 0);
    step();
    drive(2'b01, 3'b000, 32'h8000_0040, 32'h8, 32'd3, 32'd3, 1'b0);
    step(); in_valid = 0;
    chk("init01_lookup", lookup_taken, 1);
    chk("init01_stat_br", stat_branches, 1);

    for (int i = 0; i < 20; i++) begin
      drive(2'b01, 3'b001, 32'h8000_0800, 32'h8, 32'd9, 32'd9, 1'b1);
      step();
    end
    in_valid = 0;
    chk("sat_stat_br", stat_branches, 4'hF);
    chk("sat_stat_mp", stat_mispredicts, 4'hF);
    step(); step();

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
